quad_encoder_gen: RTL and testbench

Multi-channel, rate-limited quadrature encoder emulator. It is the parametrised successor to the single-channel CW/CCW step-to-Gray block. Each channel accepts CW/CCW step pulses and queues them as a signed backlog. It replays the backlog on A/B at a programmable minimum edge spacing, tracks shaft position modulo counts-per-revolution, and drives an index (Z) output. It sits between motion-command logic and anything that consumes encoder signals, such as a motor-controller model or a QEI under test.

---
 rtl/encoder_pkg.sv | 30 +++
 rtl/quad_encoder_ch.sv | 108 ++++++++++
 rtl/quad_encoder_gen.sv | 48 ++++
 tb/tb_quad_encoder_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the quadrature encoder emulator: Gray quadrant
// encoding of {a,b} and the one-quadrant advance functions.
package encoder_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b10,
    Q2 = 2'b11,
    Q3 = 2'b01
  } quad_e;

  function automatic quad_e next_cw(input quad_e q);
    case (q)
      Q0:      return Q1;
      Q1:      return Q2;
      Q2:      return Q3;
      default: return Q0;
    endcase
  endfunction

  function automatic quad_e next_ccw(input quad_e q);
    case (q)
      Q0:      return Q3;
      Q3:      return Q2;
      Q2:      return Q1;
      default: return Q0;
    endcase
  endfunction

endpackage

// File: rtl/quad_encoder_ch.sv
// One encoder channel: signed step backlog, edge pacing, Gray quadrant,
// position modulo PPR, index and sticky saturation flag.
module quad_encoder_ch
  import encoder_pkg::*;
#(
  parameter int PPR    = 1024,
  parameter int POS_W  = 16,
  parameter int PEND_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_cw,
  input  logic             step_ccw,
  input  logic [DIV_W-1:0] div,
  input  logic             clr_ovf,
  output logic             a,
  output logic             b,
  output logic             z,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             ovf
);

  localparam logic signed [PEND_W-1:0] P_ONE  = PEND_W'(1);
  localparam logic signed [PEND_W-1:0] P_MAX  = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W-1:0] P_MIN  = -P_MAX;
  localparam logic        [POS_W-1:0]  POS_LAST = POS_W'(PPR - 1);

  quad_e                    quad_q, quad_d;
  logic signed [PEND_W-1:0] pend_q, pend_d;
  logic        [DIV_W-1:0]  tmr_q, tmr_d;
  logic        [POS_W-1:0]  pos_q, pos_d;
  logic                     z_q, z_d;
  logic                     busy_q, busy_d;
  logic                     ovf_q, ovf_d;

  logic                     req_up, req_dn, sat_hit, step_ok;
  logic signed [PEND_W-1:0] eff;
  logic        [DIV_W-1:0]  tmr_load;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    req_up   = step_cw && !step_ccw;
    req_dn   = step_ccw && !step_cw;
    // A request that would push the backlog past its clamp is dropped.
    sat_hit  = (req_up && pend_q == P_MAX) || (req_dn && pend_q == P_MIN);
    eff      = pend_q;
    if (req_up && !sat_hit) eff = pend_q + P_ONE;
    if (req_dn && !sat_hit) eff = pend_q - P_ONE;

    tmr_load = (div == '0) ? '0 : div - DIV_W'(1);
    step_ok  = (tmr_q == '0) && (eff != '0);

    quad_d = quad_q;
    pend_d = eff;
    tmr_d  = (tmr_q == '0) ? '0 : tmr_q - DIV_W'(1);
    pos_d  = pos_q;

    if (step_ok) begin
      tmr_d = tmr_load;
      if (!eff[PEND_W-1]) begin
        quad_d = next_cw(quad_q);
        pend_d = eff - P_ONE;
        pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
      end else begin
        quad_d = next_ccw(quad_q);
        pend_d = eff + P_ONE;
        pos_d  = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
      end
    end

    ovf_d  = sat_hit ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    z_d    = (pos_d == '0);
    busy_d = (pend_d != '0);
  end

  // NOTE: state registers use non-blocking assignments only; reset is
  // synchronous, so requests seen in a reset cycle are simply discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      quad_q <= Q0;
      pend_q <= '0;
      tmr_q  <= '0;
      pos_q  <= '0;
      z_q    <= 1'b1;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      quad_q <= quad_d;
      pend_q <= pend_d;
      tmr_q  <= tmr_d;
      pos_q  <= pos_d;
      z_q    <= z_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign a    = quad_q[1];
  assign b    = quad_q[0];
  assign z    = z_q;
  assign pos  = pos_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/quad_encoder_gen.sv
// Multi-channel rate-limited quadrature encoder emulator: NUM_CH independent
// channels sharing the edge-spacing divisor and the overflow clear.
module quad_encoder_gen
  import encoder_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int PPR    = 1024,
  parameter int POS_W  = 16,
  parameter int PEND_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       step_cw,
  input  logic [NUM_CH-1:0]       step_ccw,
  input  logic [DIV_W-1:0]        div,
  input  logic                    clr_ovf,
  output logic [NUM_CH-1:0]       a,
  output logic [NUM_CH-1:0]       b,
  output logic [NUM_CH-1:0]       z,
  output logic [NUM_CH*POS_W-1:0] pos,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       ovf
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    quad_encoder_ch #(
      .PPR   (PPR),
      .POS_W (POS_W),
      .PEND_W(PEND_W),
      .DIV_W (DIV_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .step_cw (step_cw[i]),
      .step_ccw(step_ccw[i]),
      .div     (div),
      .clr_ovf (clr_ovf),
      .a       (a[i]),
      .b       (b[i]),
      .z       (z[i]),
      .pos     (pos[i*POS_W +: POS_W]),
      .busy    (busy[i]),
      .ovf     (ovf[i])
    );
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: a default-parameter instance plus a
// PEND_W=4 instance for backlog saturation.
module tb_quad_encoder_gen;

  localparam int POS_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        step_cw, step_ccw, step2_cw, step2_ccw;
  logic [15:0]       div;
  logic              clr_ovf;
  logic [1:0]        a, b, z, busy, ovf;
  logic [2*POS_W-1:0] pos;
  logic [1:0]        a2, b2, z2, busy2, ovf2;
  logic [2*POS_W-1:0] pos2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quad_encoder_gen dut (
    .clk(clk), .rst(rst), .step_cw(step_cw), .step_ccw(step_ccw), .div(div),
    .clr_ovf(clr_ovf), .a(a), .b(b), .z(z), .pos(pos), .busy(busy), .ovf(ovf)
  );

  quad_encoder_gen #(.PEND_W(4)) dut2 (
    .clk(clk), .rst(rst), .step_cw(step2_cw), .step_ccw(step2_ccw), .div(div),
    .clr_ovf(clr_ovf), .a(a2), .b(b2), .z(z2), .pos(pos2), .busy(busy2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    step_cw  = '0;
    step_ccw = '0;
    step2_cw = '0;
    step2_ccw = '0;
    clr_ovf  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [1:0] ab0();
    return {a[0], b[0]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] cw_seq [4];
    logic [1:0] ccw_seq[3];
    logic [1:0] prev;
    int         n_edge;
    int         e_t  [3];
    logic [1:0] e_ab [3];
    int         e_pos[3];
    logic       idle_bad;
    logic       busy_mid;
    logic       ovf_mid;

    cw_seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
    ccw_seq = '{2'b01, 2'b11, 2'b10};
    div = 16'd1;
    do_reset();
    tick();

    // Reset state, both channels
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_z", z, 2'b11);
    check("rst_pos", pos, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);

    idle_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({a, b} != 4'b0 || z != 2'b11 || pos != '0 || busy != 2'b0) idle_bad = 1'b1;
    end
    check("idle_stable", idle_bad, 0);

    // div=1: four CW pulses step one quadrant per cycle
    for (int i = 0; i < 4; i++) begin
      step_cw = 2'b01;
      tick();
      check($sformatf("cw_ab%0d", i), ab0(), cw_seq[i]);
      check($sformatf("cw_pos%0d", i), pos[POS_W-1:0], i + 1);
    end
    step_cw = '0;
    tick();
    check("cw_pos_final", pos[POS_W-1:0], 4);
    check("cw_busy_final", busy[0], 0);
    check("cw_ch1_pos", pos[2*POS_W-1:POS_W], 0);

    // div=5: three CCW requests, edges 5 cycles apart
    do_reset();
    div = 16'd5;
    prev = ab0();
    n_edge = 0;
    e_t = '{default: -1};
    e_ab = '{default: 2'b00};
    e_pos = '{default: -1};
    for (int i = 1; i <= 14; i++) begin
      step_ccw = (i <= 3) ? 2'b01 : 2'b00;
      tick();
      if (i == 1) check("ccw_z_fall", z[0], 0);
      if (ab0() != prev) begin
        if (n_edge < 3) begin
          e_t[n_edge]   = i;
          e_ab[n_edge]  = ab0();
          e_pos[n_edge] = int'(pos[POS_W-1:0]);
        end
        n_edge++;
        prev = ab0();
      end
    end
    check("ccw_edges", n_edge, 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ccw_t%0d", k), e_t[k], 1 + 5 * k);
      check($sformatf("ccw_ab%0d", k), e_ab[k], ccw_seq[k]);
      check($sformatf("ccw_pos%0d", k), e_pos[k], 1023 - k);
    end
    check("ccw_busy_end", busy[0], 0);

    // Simultaneous cw&ccw: no motion at all
    do_reset();
    div = 16'd1;
    prev = ab0();
    n_edge = 0;
    for (int i = 0; i < 20; i++) begin
      step_cw  = 2'b01;
      step_ccw = 2'b01;
      tick();
      if (ab0() != prev) n_edge++;
      prev = ab0();
    end
    step_cw = '0;
    step_ccw = '0;
    check("both_edges", n_edge, 0);
    check("both_busy", busy[0], 0);
    check("both_pos", pos[POS_W-1:0], 0);

    // div=8: one CW edge, then 2 CW + 2 CCW queued inside the interval cancel
    prev = ab0();
    n_edge = 0;
    busy_mid = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      step_cw  = (i <= 3) ? 2'b01 : 2'b00;
      step_ccw = (i == 4 || i == 5) ? 2'b01 : 2'b00;
      div = 16'd8;
      tick();
      if (i == 1) check("cancel_first_edge", ab0(), 2'b10);
      if (i == 3) busy_mid = busy[0];
      if (ab0() != prev) n_edge++;
      prev = ab0();
    end
    check("cancel_busy_mid", busy_mid, 1);
    check("cancel_edges", n_edge, 1);
    check("cancel_pos", pos[POS_W-1:0], 1);
    check("cancel_busy_end", busy[0], 0);

    // Saturation on the PEND_W=4 instance: clamp at 7, ovf sticky, set beats clear
    do_reset();
    div = 16'd100;
    prev = {a2[0], b2[0]};
    n_edge = 0;
    ovf_mid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step2_cw = 2'b01;
      clr_ovf  = (i == 10);
      tick();
      if (i == 8) ovf_mid = ovf2[0];
      if ({a2[0], b2[0]} != prev) n_edge++;
      prev = {a2[0], b2[0]};
    end
    step2_cw = '0;
    check("sat_ovf_before", ovf_mid, 0);
    check("sat_ovf_set_wins", ovf2[0], 1);
    check("sat_busy", busy2[0], 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("sat_ovf_cleared", ovf2[0], 0);
    if ({a2[0], b2[0]} != prev) n_edge++;
    prev = {a2[0], b2[0]};
    for (int i = 0; i < 740; i++) begin
      tick();
      if ({a2[0], b2[0]} != prev) n_edge++;
      prev = {a2[0], b2[0]};
    end
    check("sat_total_edges", n_edge, 8);
    check("sat_pos", pos2[POS_W-1:0], 8);
    check("sat_busy_end", busy2[0], 0);
    check("sat_ovf_end", ovf2[0], 0);

    // Wrap through a full revolution
    do_reset();
    div = 16'd1;
    for (int i = 0; i < 1023; i++) begin
      step_cw = 2'b01;
      tick();
    end
    check("wrap_pos_last", pos[POS_W-1:0], 1023);
    check("wrap_z_before", z[0], 0);
    tick();
    step_cw = '0;
    check("wrap_pos_zero", pos[POS_W-1:0], 0);
    check("wrap_z_at_zero", z[0], 1);
    tick();
    check("wrap_z_hold", z[0], 1);
    step_ccw = 2'b01;
    tick();
    step_ccw = '0;
    check("wrap_ccw_pos", pos[POS_W-1:0], 1023);
    check("wrap_ccw_z", z[0], 0);

    // Reset mid-drain, with independent channel 1 traffic
    do_reset();
    div = 16'd100;
    for (int i = 0; i < 6; i++) begin
      step_cw  = 2'b01;
      step_ccw = (i < 3) ? 2'b10 : 2'b00;
      tick();
    end
    step_cw = '0;
    step_ccw = '0;
    check("drain_ch0_pos", pos[POS_W-1:0], 1);
    check("drain_ch1_pos", pos[2*POS_W-1:POS_W], 1023);
    check("drain_busy", busy, 2'b11);
    rst = 1'b1;
    step_cw = 2'b01;
    tick();
    rst = 1'b0;
    step_cw = '0;
    check("mid_rst_ab", {a, b}, 0);
    check("mid_rst_pos", pos, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_z", z, 2'b11);
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_pos", pos, 0);
    check("post_rst_ab", {a, b}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
